// File: rtl/mem_access.sv
// mem_access: memory-access stage of the mriscv pipeline (loads, stores, pass-through to write-back).
// Latency: pass-through 1 cycle; memory op issues mem_req 1 cycle after accept, wb_valid 1 cycle after the mem_ack edge.
// Backpressure: in_ready is low for the whole bus transaction; write-back has no backpressure.
//
// Ports: clk/reset (async active-low); in_* instruction from execute with valid/ready;
//        mem_* single-outstanding req/ack data bus; wb_* one-cycle write-back pulse; misaligned_o fault flag.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module mem_access #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic [2:0]            in_func3,
    input  logic [31:0]           in_addr,
    input  logic [31:0]           in_store_data,
    input  logic [4:0]            in_dest,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic                  wb_valid,
    output logic [4:0]            wb_dest,
    output logic [31:0]           wb_data,
    output logic                  misaligned_o
);

    typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

    state_t      state;
    logic [2:0]  ld_func3;
    logic [1:0]  ld_off;
    logic [4:0]  ld_dest;
    logic        ld_is_load;

    logic        hs;
    logic        is_mem;
    logic        acc_byte;
    logic        acc_half;
    logic        trap;
    logic [1:0]  off_eff;
    logic [3:0]  strb_n;
    logic [31:0] wdata_n;
    logic [31:0] rsh;
    logic [31:0] load_val;

    assign in_ready = (state == IDLE);
    assign hs       = in_valid && in_ready;
    assign is_mem   = in_is_load || in_is_store;

    // Access size. Stores only recognise sb/sh exactly (everything else is a
    // word); loads decode size from func3[1:0] so lbu/lhu share lb/lh sizing.
    always_comb begin
        acc_byte = 1'b0;
        acc_half = 1'b0;
        if (in_is_store) begin
            acc_byte = (in_func3 == 3'b000);
            acc_half = (in_func3 == 3'b001);
        end else begin
            acc_byte = (in_func3[1:0] == 2'b00);
            acc_half = (in_func3[1:0] == 2'b01);
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = is_mem && ((acc_half && in_addr[0]) ||
                             (!acc_byte && !acc_half && (in_addr[1:0] != 2'b00)));
`else
    // Without trapping, misaligned accesses are silently force-aligned via off_eff.
    assign trap = 1'b0;
`endif

    // Byte offset after force-alignment to the access size.
    always_comb begin
        if (acc_byte)      off_eff = in_addr[1:0];
        else if (acc_half) off_eff = {in_addr[1], 1'b0};
        else               off_eff = 2'b00;
    end

    always_comb begin
        if (acc_byte) begin
            strb_n  = 4'b0001 << off_eff;
            wdata_n = {4{in_store_data[7:0]}};
        end else if (acc_half) begin
            strb_n  = 4'b0011 << off_eff;
            wdata_n = {2{in_store_data[15:0]}};
        end else begin
            strb_n  = 4'b1111;
            wdata_n = in_store_data;
        end
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend.
    assign rsh = mem_rdata >> {ld_off, 3'b000};

    always_comb begin
        case (ld_func3)
            3'b000:  load_val = {{24{rsh[7]}}, rsh[7:0]};
            3'b001:  load_val = {{16{rsh[15]}}, rsh[15:0]};
            3'b100:  load_val = {24'd0, rsh[7:0]};
            3'b101:  load_val = {16'd0, rsh[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            wb_valid     <= 1'b0;
            wb_dest      <= '0;
            wb_data      <= '0;
            misaligned_o <= 1'b0;
            ld_func3     <= '0;
            ld_off       <= '0;
            ld_dest      <= '0;
            ld_is_load   <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            misaligned_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs) begin
                        if (!is_mem) begin
                            wb_valid <= 1'b1;
                            wb_dest  <= in_dest;
                            wb_data  <= in_addr;
                        end else if (trap) begin
                            wb_valid     <= 1'b1;
                            misaligned_o <= 1'b1;
                            wb_dest      <= '0;
                            wb_data      <= in_addr;
                        end else begin
                            state      <= BUS;
                            mem_req    <= 1'b1;
                            mem_we     <= in_is_store;
                            mem_addr   <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata  <= in_is_store ? wdata_n : 32'd0;
                            mem_wstrb  <= in_is_store ? strb_n  : 4'd0;
                            // A request flagged as both load and store is treated as a store.
                            ld_is_load <= !in_is_store;
                            ld_func3   <= in_func3;
                            ld_off     <= off_eff;
                            ld_dest    <= in_dest;
                        end
                    end
                end
                BUS: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_dest  <= ld_is_load ? ld_dest  : 5'd0;
                        wb_data  <= ld_is_load ? load_val : 32'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: self-checking bench for mem_access with a responder-driven data bus.
// Latency: n/a (testbench).
// Backpressure: bench waits on in_ready/mem_req with bounded cycle budgets.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_load;
    logic        in_is_store;
    logic [2:0]  in_func3;
    logic [31:0] in_addr;
    logic [31:0] in_store_data;
    logic [4:0]  in_dest;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        misaligned_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_func3(in_func3), .in_addr(in_addr),
        .in_store_data(in_store_data), .in_dest(in_dest),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .misaligned_o(misaligned_o)
    );

    always #5 clk = ~clk;

    // Observations of the most recent transaction.
    int          obs_lat;
    int          obs_wb_cnt;
    int          obs_req_cycles;
    bit          obs_req_seen;
    bit          obs_stable;
    bit          obs_ready_in_bus;
    bit          obs_rdy_at_issue;
    logic        obs_we;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [3:0]  obs_wstrb;
    logic [4:0]  obs_wb_dest;
    logic [31:0] obs_wb_data;
    logic        obs_mis;

    // Expected values from the reference model.
    bit          e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [4:0]  e_dest;
    logic [31:0] e_data;
    logic        e_mis;

    // Behavioural model: access size in bytes, offset arithmetic, lane loops.
    task automatic model(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] d, input logic [31:0] rd);
        int     n;
        int     off;
        longint v;
        e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0; e_mis = 0;
        if (!ld && !st) begin
            e_dest = d;
            e_data = a;
            return;
        end
        if (st) n = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
        else    n = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
`ifdef MEM_MISALIGN_TRAP_EN
        if ((a % n) != 0) begin
            e_mis  = 1;
            e_dest = 0;
            e_data = a;
            return;
        end
`endif
        off    = int'(a % 4) - int'((a % 4) % n);
        e_req  = 1;
        e_addr = a - (a % 4);
        if (st) begin
            e_we = 1;
            for (int i = 0; i < 4; i++) begin
                e_wstrb[i] = (i >= off) && (i < off + n);
                e_wdata[8*i +: 8] = sd[8*(i % n) +: 8];
            end
            e_dest = 0;
            e_data = 0;
        end else begin
            v = longint'(rd) >> (8 * off);
            if (n < 4) begin
                v = v % (longint'(1) << (8 * n));
                if ((f3 == 0 || f3 == 1) && v >= (longint'(1) << (8 * n - 1)))
                    v = v - (longint'(1) << (8 * n));
            end
            e_dest = d;
            e_data = v[31:0];
        end
    endtask

    // Issues one instruction, acts as the memory (ack after dly extra cycles), records what happened.
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] d, input int dly, input logic [31:0] rd);
        int cyc;
        bit done;
        obs_lat = 0; obs_wb_cnt = 0; obs_req_cycles = 0; obs_req_seen = 0;
        obs_stable = 1; obs_ready_in_bus = 0; obs_mis = 0;
        obs_wb_dest = 'x; obs_wb_data = 'x;
        @(negedge clk);
        obs_rdy_at_issue = in_ready;
        in_valid = 1; in_is_load = ld; in_is_store = st; in_func3 = f3;
        in_addr = a; in_store_data = sd; in_dest = d;
        @(posedge clk);
        #1;
        in_valid = 0; in_is_load = 0; in_is_store = 0;
        in_addr = $urandom; in_store_data = $urandom;
        done = 0;
        cyc  = 0;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (wb_valid) begin
                obs_wb_cnt++;
                obs_lat     = cyc;
                obs_wb_dest = wb_dest;
                obs_wb_data = wb_data;
                obs_mis     = misaligned_o;
                done        = 1;
                mem_ack     = 0;
            end else if (mem_req) begin
                if (!obs_req_seen) begin
                    obs_addr = mem_addr; obs_we = mem_we;
                    obs_wdata = mem_wdata; obs_wstrb = mem_wstrb;
                end else if (obs_addr !== mem_addr || obs_we !== mem_we ||
                             obs_wdata !== mem_wdata || obs_wstrb !== mem_wstrb) begin
                    obs_stable = 0;
                end
                obs_req_seen = 1;
                obs_req_cycles++;
                if (in_ready) obs_ready_in_bus = 1;
                if (obs_req_cycles == dly + 1) begin
                    mem_ack = 1; mem_rdata = rd;
                end else begin
                    mem_ack = 0; mem_rdata = $urandom;
                end
            end
        end
        mem_ack = 0;
        @(negedge clk);
        if (wb_valid) obs_wb_cnt++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if ({in_ready, mem_req, mem_we, wb_valid, misaligned_o} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 10000", {in_ready, mem_req, mem_we, wb_valid, misaligned_o});
        end
        n_tests++;
        if ({mem_addr, mem_wdata, mem_wstrb, wb_dest, wb_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data got addr=%h wdata=%h strb=%b dest=%0d data=%h want all 0",
                     mem_addr, mem_wdata, mem_wstrb, wb_dest, wb_data);
        end
    endtask

    task automatic test_passthrough();
        run_op(0, 0, 3'b000, 32'h1234_5678, 32'h0, 5'd5, 0, 32'h0);
        n_tests++;
        if (obs_wb_dest !== 5'd5 || obs_wb_data !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL pass_wb got dest=%0d data=%h want 5 12345678", obs_wb_dest, obs_wb_data);
        end
        n_tests++;
        if (obs_lat !== 1 || obs_req_seen !== 0 || obs_wb_cnt !== 1) begin
            n_fail++;
            $display("FAIL pass_timing got lat=%0d req=%0d cnt=%0d want 1 0 1", obs_lat, obs_req_seen, obs_wb_cnt);
        end
    endtask

    task automatic test_load_ext();
        run_op(1, 0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 0, 32'h80FF_0000);
        n_tests++;
        if (obs_addr !== 32'h100 || obs_we !== 0 || obs_wstrb !== 4'b0000) begin
            n_fail++;
            $display("FAIL lb_bus got addr=%h we=%b strb=%b want 100 0 0000", obs_addr, obs_we, obs_wstrb);
        end
        n_tests++;
        if (obs_wb_data !== 32'hFFFF_FF80 || obs_wb_dest !== 5'd7 || obs_lat !== 2) begin
            n_fail++;
            $display("FAIL lb_wb got data=%h dest=%0d lat=%0d want ffffff80 7 2", obs_wb_data, obs_wb_dest, obs_lat);
        end
        run_op(1, 0, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 0, 32'h80FF_0000);
        n_tests++;
        if (obs_wb_data !== 32'h0000_0080 || obs_lat !== 2) begin
            n_fail++;
            $display("FAIL lbu_wb got data=%h lat=%0d want 00000080 2", obs_wb_data, obs_lat);
        end
        // Load to x0 still performs the bus access.
        run_op(1, 0, 3'b010, 32'h0000_0040, 32'h0, 5'd0, 1, 32'hCAFE_F00D);
        n_tests++;
        if (obs_req_seen !== 1 || obs_wb_dest !== 5'd0 || obs_wb_cnt !== 1) begin
            n_fail++;
            $display("FAIL lw_x0 got req=%0d dest=%0d cnt=%0d want 1 0 1", obs_req_seen, obs_wb_dest, obs_wb_cnt);
        end
    endtask

    task automatic test_store_sh();
        run_op(0, 1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 5'd9, 0, 32'h0);
        n_tests++;
        if (obs_we !== 1 || obs_wstrb !== 4'b1100 || obs_wdata !== 32'hBEEF_BEEF || obs_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL sh_bus got we=%b strb=%b wdata=%h addr=%h want 1 1100 beefbeef 200",
                     obs_we, obs_wstrb, obs_wdata, obs_addr);
        end
        n_tests++;
        if (obs_wb_dest !== 5'd0 || obs_wb_data !== 32'd0) begin
            n_fail++;
            $display("FAIL sh_wb got dest=%0d data=%h want 0 0", obs_wb_dest, obs_wb_data);
        end
    endtask

    task automatic test_stall();
        run_op(0, 1, 3'b010, 32'h0000_0400, 32'h1357_9BDF, 5'd3, 3, 32'h0);
        n_tests++;
        if (obs_stable !== 1 || obs_req_cycles !== 4 || obs_wdata !== 32'h1357_9BDF) begin
            n_fail++;
            $display("FAIL sw_stall_bus got stable=%0d reqcyc=%0d wdata=%h want 1 4 13579bdf",
                     obs_stable, obs_req_cycles, obs_wdata);
        end
        n_tests++;
        if (obs_ready_in_bus !== 0 || obs_wb_cnt !== 1 || obs_lat !== 5) begin
            n_fail++;
            $display("FAIL sw_stall_wb got ready_in_bus=%0d cnt=%0d lat=%0d want 0 1 5",
                     obs_ready_in_bus, obs_wb_cnt, obs_lat);
        end
    endtask

    task automatic test_misaligned();
        run_op(1, 0, 3'b010, 32'h0000_0301, 32'h0, 5'd4, 0, 32'h1111_2222);
`ifdef MEM_MISALIGN_TRAP_EN
        n_tests++;
        if (obs_req_seen !== 0 || obs_mis !== 1 || obs_wb_data !== 32'h301 || obs_wb_dest !== 0) begin
            n_fail++;
            $display("FAIL lw_trap got req=%0d mis=%b data=%h dest=%0d want 0 1 301 0",
                     obs_req_seen, obs_mis, obs_wb_data, obs_wb_dest);
        end
`else
        n_tests++;
        if (obs_addr !== 32'h300 || obs_mis !== 0 || obs_wb_data !== 32'h1111_2222) begin
            n_fail++;
            $display("FAIL lw_align got addr=%h mis=%b data=%h want 300 0 11112222",
                     obs_addr, obs_mis, obs_wb_data);
        end
`endif
    endtask

    task automatic test_idle_ack();
        int bad;
        bad = 0;
        @(negedge clk);
        mem_ack = 1;
        repeat (3) begin
            @(negedge clk);
            if (wb_valid || mem_req) bad++;
        end
        mem_ack = 0;
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL idle_ack got %0d spurious cycles want 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        logic [31:0] exp_d;
        bad = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_is_load = 0; in_is_store = 0;
            in_addr = 32'hA000_0000 + i; in_dest = 5'(i + 1);
            @(negedge clk);
            exp_d = 32'hA000_0000 + i;
            if (!wb_valid || wb_data !== exp_d || wb_dest !== 5'(i + 1)) bad++;
        end
        in_valid = 0;
        @(negedge clk);
        n_tests++;
        if (bad !== 0 || wb_valid !== 0) begin
            n_fail++;
            $display("FAIL back_to_back got %0d bad beats, trailing wb=%b want 0 0", bad, wb_valid);
        end
    endtask

    task automatic test_reset_mid_bus();
        int bad;
        bad = 0;
        @(negedge clk);
        in_valid = 1; in_is_load = 1; in_is_store = 0; in_func3 = 3'b010;
        in_addr = 32'h500; in_dest = 5'd3;
        @(posedge clk);
        #1;
        in_valid = 0; in_is_load = 0;
        @(negedge clk);
        n_tests++;
        if (mem_req !== 1) begin
            n_fail++;
            $display("FAIL rst_bus_pre got mem_req=%b want 1", mem_req);
        end
        #2 reset = 0;
        #1;
        n_tests++;
        if (mem_req !== 0) begin
            n_fail++;
            $display("FAIL rst_bus_async got mem_req=%b want 0", mem_req);
        end
        mem_ack = 1;
        repeat (2) begin
            @(negedge clk);
            if (wb_valid) bad++;
        end
        reset = 1;
        mem_ack = 0;
        repeat (3) begin
            @(negedge clk);
            if (wb_valid || mem_req) bad++;
        end
        n_tests++;
        if (bad !== 0 || in_ready !== 1) begin
            n_fail++;
            $display("FAIL rst_bus_after got bad=%0d in_ready=%b want 0 1", bad, in_ready);
        end
        run_op(0, 0, 3'b000, 32'h0BAD_F00D, 32'h0, 5'd12, 0, 32'h0);
        n_tests++;
        if (obs_wb_data !== 32'h0BAD_F00D || obs_wb_dest !== 5'd12 || obs_lat !== 1) begin
            n_fail++;
            $display("FAIL rst_bus_pass got data=%h dest=%0d lat=%0d want 0badf00d 12 1",
                     obs_wb_data, obs_wb_dest, obs_lat);
        end
    endtask

    task automatic test_random();
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] a, sd, rd;
        logic [4:0]  d;
        int          dly, kind, exp_lat;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            ld = (kind == 1); st = (kind == 2);
            f3 = 3'($urandom_range(0, 7));
            a = $urandom; sd = $urandom; rd = $urandom;
            d = 5'($urandom_range(0, 31));
            dly = $urandom_range(0, 3);
            model(ld, st, f3, a, sd, d, rd);
            exp_lat = e_req ? dly + 2 : 1;
            run_op(ld, st, f3, a, sd, d, dly, rd);
            n_tests++;
            if (obs_wb_dest !== e_dest || obs_wb_data !== e_data || obs_mis !== e_mis) begin
                n_fail++;
                $display("FAIL rand%0d_wb ld=%b st=%b f3=%0d a=%h got dest=%0d data=%h mis=%b want %0d %h %b",
                         i, ld, st, f3, a, obs_wb_dest, obs_wb_data, obs_mis, e_dest, e_data, e_mis);
            end
            n_tests++;
            if (obs_lat !== exp_lat || obs_req_seen !== e_req || obs_wb_cnt !== 1 || obs_rdy_at_issue !== 1) begin
                n_fail++;
                $display("FAIL rand%0d_timing got lat=%0d req=%0d cnt=%0d rdy=%0d want %0d %0d 1 1",
                         i, obs_lat, obs_req_seen, obs_wb_cnt, obs_rdy_at_issue, exp_lat, e_req);
            end
            if (e_req) begin
                n_tests++;
                if (obs_addr !== e_addr || obs_we !== e_we || obs_wstrb !== e_wstrb ||
                    (st && obs_wdata !== e_wdata) || obs_stable !== 1) begin
                    n_fail++;
                    $display("FAIL rand%0d_bus got addr=%h we=%b strb=%b wdata=%h stable=%0d want %h %b %b %h 1",
                             i, obs_addr, obs_we, obs_wstrb, obs_wdata, obs_stable,
                             e_addr, e_we, e_wstrb, e_wdata);
                end
            end
        end
    endtask

    initial begin
        reset = 0; in_valid = 0; in_is_load = 0; in_is_store = 0; in_func3 = 0;
        in_addr = 0; in_store_data = 0; in_dest = 0; mem_ack = 0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1;
        test_reset();
        test_passthrough();
        test_load_ext();
        test_store_sh();
        test_stall();
        test_misaligned();
        test_idle_ack();
        test_back_to_back();
        test_reset_mid_bus();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the mriscv pipeline, placed directly downstream of `execute`. It takes one instruction at a time from `execute`: the ALU result or effective address, the store data, the destination register and `func3`. Loads and stores go through a single-outstanding request/acknowledge data-memory bus, with byte-lane steering and load sign/zero extension. Every accepted instruction yields exactly one write-back pulse toward the register file.

## Interface
- `ADDR_WIDTH`, 32, width of `mem_addr`; the upper bits of `in_addr` beyond this width are dropped.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream holds an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_is_load`, `in_is_store`  in  1 each  access type; neither set = pass-through
- `in_func3`  in  3  access size/signedness (RV32I encoding)
- `in_addr`  in  32  effective address, or the result to pass through
- `in_store_data`  in  32  rs2 value for stores
- `in_dest`  in  5  destination register
- `mem_req`  out  1  bus request, held until acknowledged
- `mem_we`  out  1  1 = write
- `mem_addr`  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
- `mem_wdata`  out  32  lane-replicated store data
- `mem_wstrb`  out  4  byte enables (0 for reads)
- `mem_ack`  in  1  bus completion; `mem_rdata` is valid in the same cycle
- `mem_rdata`  in  32  read word
- `wb_valid`  out  1  one-cycle write-back pulse
- `wb_dest`  out  5  write-back register; 0 = no write
- `wb_data`  out  32  write-back value
- `misaligned_o`  out  1  misaligned access fault, pulses together with `wb_valid`

## Operation
- FSM states: IDLE, BUS.
  - `in_ready` = (state == IDLE).
  - A handshake occurs when `in_valid` && `in_ready`.
- Pass-through (neither load nor store): stays in IDLE; next edge `wb_valid`=1, `wb_dest`=`in_dest`, `wb_data`=`in_addr`.
- Memory op: inputs are latched and the FSM moves to BUS.
  - In BUS: `mem_req`=1; `mem_addr`, `mem_we`, `mem_wdata`, `mem_wstrb` come from registers and are stable until ack.
  - Edge with `mem_ack`=1 in BUS: return to IDLE and pulse `wb_valid`.
  - `mem_ack` outside BUS is ignored.
- Store lanes use `in_addr[1:0]`:
  - sb (000): strb = 4'b0001<<a; wdata = byte replicated ×4.
  - sh (001): strb = 4'b0011<<a; wdata = half replicated ×2.
  - sw (010, and any other func3): strb = 4'b1111.
  - A store's write-back has `wb_dest`=0 and `wb_data`=0.
- Load extraction selects the byte/half at the offset, then extends:
  - lb 000 sign, lh 001 sign, lbu 100 zero, lhu 101 zero.
  - lw 010 and reserved codes (011, 110, 111) return the full word.
  - `wb_dest`=`in_dest`.
- Misaligned: half with a[0]=1, or word with a[1:0]≠0; handled per Configuration.
- `in_dest`=0 on a load still performs the bus access; `wb_dest`=0.

## Timing
- Reset values: state IDLE, `in_ready`=1, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `wb_valid`=0, `wb_dest`=0, `wb_data`=0, `misaligned_o`=0.
- Latency:
  - Pass-through: 1 cycle after the handshake.
  - Memory op: `mem_req` rises 1 cycle after the handshake. `wb_valid` follows 1 cycle after the edge on which `mem_ack` is sampled, so a zero-wait memory gives 2 cycles from handshake to write-back.
- Throughput:
  - Pass-through: one per cycle.
  - Memory ops: no new handshake while in BUS.
- `wb_valid` is registered and lasts exactly one cycle; there is no back-pressure from write-back.
- Reset asserted mid-BUS: `mem_req` drops asynchronously, no write-back is produced, and the request is abandoned. The memory must tolerate the dropped request.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A misaligned load or store issues no bus request.
  - Next edge: `wb_valid`=1, `misaligned_o`=1, `wb_dest`=0, `wb_data`=faulting address.
  - The FSM stays in IDLE.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - The address is force-aligned: half clears bit 0, word clears [1:0].
  - The access proceeds normally.
  - `misaligned_o` is tied to 0.

## Test plan
- Pass-through: addr=0x1234_5678, dest=5 -> next cycle `wb_valid`=1, `wb_dest`=5, `wb_data`=0x1234_5678; `mem_req` stays 0.
- lb at 0x103 with `mem_rdata`=0x80FF_0000 and ack on the first BUS cycle -> `mem_addr`=0x100, `wb_data`=0xFFFF_FF80; the same case with lbu -> 0x0000_0080; handshake-to-`wb_valid` = 2 cycles.
- sh at 0x202 with data 0xDEAD_BEEF -> `mem_we`=1, `mem_wstrb`=4'b1100, `mem_wdata`=0xBEEF_BEEF, `wb_dest`=0.
- sw held 3 cycles before ack -> request fields stable throughout; `in_ready`=0 until the ack edge; exactly one `wb_valid`.
- lw at 0x301:
  - With `MEM_MISALIGN_TRAP_EN`: no `mem_req`; `misaligned_o`=1 with `wb_data`=0x301.
  - Without it: `mem_addr`=0x300.
- `reset` pulled low while in BUS -> `mem_req`=0 immediately, no `wb_valid`; after release `in_ready`=1 and the next pass-through completes normally.
